rgmii_rx_framer: RTL and testbench

RGMII_RX_FRAMER -- requirements
Module: rgmii_rx_framer

---
 rtl/eth_rx_pkg.sv | 34 +++
 rtl/rgmii_rx_framer_if.sv | 14 +
 rtl/iddr.sv | 46 ++++
 rtl/rgmii_rx_framer.sv | 219 +++++++++++++++++++++
 tb/tb_rgmii_rx_framer.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_rx_pkg.sv
// Shared definitions for the RGMII receive framer: FSM state encoding,
// Ethernet preamble/SFD byte values and the CRC-32 constants with a
// byte-wide CRC update helper (used only when the FCS check is built in).
package eth_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } rx_state_e;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

    // Serial Ethernet CRC-32 advanced by one byte. Bits enter LSB first
    // (wire order), so the register stays in normal bit order and the
    // good-frame residue is CRC_RESIDUE.
    function automatic logic [31:0] crc32_next(input logic [31:0] crc,
                                               input logic [7:0]  data);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            fb = c[31] ^ data[i];
            c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0000_0000);
        end
        return c;
    endfunction

endpackage

// File: rtl/rgmii_rx_framer_if.sv
// Receive-side stream and frame-status bundle produced by rgmii_rx_framer.
// The master modport drives it, the slave modport consumes it.
interface rgmii_rx_framer_if;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        tlast;
    logic        tuser;
    logic        frame_done;
    logic        frame_err;
    logic [15:0] frame_len;

    modport master (output tdata, tvalid, tlast, tuser, frame_done, frame_err, frame_len);
    modport slave  (input  tdata, tvalid, tlast, tuser, frame_done, frame_err, frame_len);
endinterface

// File: rtl/iddr.sv
// Generic DDR input capture: rising-edge and falling-edge samples of d are
// re-registered together on the following rising edge so q1 (rise) and
// q2 (fall) belong to the same clock period.
module iddr #(
    parameter int WIDTH = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2
);

    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;

    // Rising-edge sample of the DDR pins.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rise_q <= '0;
        end else begin
            rise_q <= d;
        end
    end

    // Falling-edge sample of the DDR pins.
    always_ff @(negedge clk_i) begin
        if (rst_i) begin
            fall_q <= '0;
        end else begin
            fall_q <= d;
        end
    end

    // Realign the rise/fall pair into the rising-edge domain.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q1 <= '0;
            q2 <= '0;
        end else begin
            q1 <= rise_q;
            q2 <= fall_q;
        end
    end

endmodule

// File: rtl/rgmii_rx_framer.sv
// RGMII receive framer: DDR capture, preamble/SFD detection, byte stream
// with a one-byte hold stage so the final byte carries tlast, and per-frame
// status (error, length). Optional FCS check: define RGMII_RX_FCS_CHECK_EN.
module rgmii_rx_framer
    import eth_rx_pkg::*;
#(
    parameter int MIN_FRAME_LEN = 64,
    parameter int MAX_FRAME_LEN = 1518
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  rgmii_rxd_i,
    input  logic        rgmii_rx_ctl_i,
    output logic [7:0]  m_tdata_o,
    output logic        m_tvalid_o,
    output logic        m_tlast_o,
    output logic        m_tuser_o,
    output logic        frame_done_o,
    output logic        frame_err_o,
    output logic [15:0] frame_len_o
);

    logic [4:0] rise_s, fall_s;
    logic [7:0] byte_s;
    logic       dv_s, er_s;

    iddr #(.WIDTH(5)) u_iddr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d     ({rgmii_rx_ctl_i, rgmii_rxd_i}),
        .q1    (rise_s),
        .q2    (fall_s)
    );

    assign byte_s = {fall_s[3:0], rise_s[3:0]};
    assign dv_s   = rise_s[4];
    assign er_s   = rise_s[4] ^ fall_s[4];

    rx_state_e   state_q, state_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_vld_q, hold_vld_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [7:0]  tdata_q, tdata_d;
    logic        tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
    logic        done_q, done_d, ferr_q, ferr_d;
    logic [15:0] flen_q, flen_d;
    logic        start_s, bad_s, fcs_bad_s;

`ifdef RGMII_RX_FCS_CHECK_EN
    logic [31:0] crc_q, crc_d;
    assign fcs_bad_s = (crc_q != CRC_RESIDUE);
`else
    assign fcs_bad_s = 1'b0;
`endif

    // Error status applied to the final beat of a normally terminated frame.
    assign bad_s = err_q | (cnt_q < 16'(MIN_FRAME_LEN)) | fcs_bad_s;

    // Framing FSM, hold stage, counters and output beat selection.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
`ifdef RGMII_RX_FCS_CHECK_EN
        crc_d      = crc_q;
`endif
        tdata_d    = tdata_q;
        tvalid_d   = 1'b0;
        tlast_d    = 1'b0;
        tuser_d    = 1'b0;
        done_d     = 1'b0;
        ferr_d     = 1'b0;
        flen_d     = flen_q;
        start_s    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (dv_s) begin
                    if (byte_s == PREAMBLE_BYTE) begin
                        state_d = ST_PREAMBLE;
                    end else if (byte_s == SFD_BYTE) begin
                        state_d = ST_DATA;
                        start_s = 1'b1;
                    end else begin
                        state_d = ST_DROP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PREAMBLE: begin
                if (!dv_s) begin
                    state_d = ST_IDLE;
                end else if (byte_s == PREAMBLE_BYTE) begin
                    state_d = ST_PREAMBLE;
                end else if (byte_s == SFD_BYTE) begin
                    state_d = ST_DATA;
                    start_s = 1'b1;
                end else begin
                    state_d = ST_DROP;
                end
            end
            ST_DATA: begin
                if (hold_vld_q && (cnt_q > 16'(MAX_FRAME_LEN))) begin
                    // Held byte is the first one past the limit: close as oversize.
                    tdata_d    = hold_q;
                    tvalid_d   = 1'b1;
                    tlast_d    = 1'b1;
                    tuser_d    = 1'b1;
                    done_d     = 1'b1;
                    ferr_d     = 1'b1;
                    flen_d     = cnt_q;
                    hold_vld_d = 1'b0;
                    state_d    = ST_DROP;
                end else if (dv_s) begin
                    if (hold_vld_q) begin
                        tdata_d  = hold_q;
                        tvalid_d = 1'b1;
                    end else begin
                        tvalid_d = 1'b0;
                    end
                    hold_d     = byte_s;
                    hold_vld_d = 1'b1;
                    cnt_d      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                    err_d      = err_q | er_s;
`ifdef RGMII_RX_FCS_CHECK_EN
                    crc_d      = crc32_next(crc_q, byte_s);
`endif
                end else begin
                    if (hold_vld_q) begin
                        tdata_d  = hold_q;
                        tvalid_d = 1'b1;
                        tlast_d  = 1'b1;
                        tuser_d  = bad_s;
                        ferr_d   = bad_s;
                        flen_d   = cnt_q;
                    end else begin
                        // SFD with no data behind it.
                        ferr_d   = 1'b1;
                        flen_d   = 16'd0;
                    end
                    done_d     = 1'b1;
                    hold_vld_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (!dv_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_s) begin
            hold_vld_d = 1'b0;
            cnt_d      = 16'd0;
            err_d      = 1'b0;
`ifdef RGMII_RX_FCS_CHECK_EN
            crc_d      = CRC_INIT;
`endif
        end else begin
            hold_vld_d = hold_vld_d;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            hold_q     <= 8'h00;
            hold_vld_q <= 1'b0;
            cnt_q      <= 16'd0;
            err_q      <= 1'b0;
`ifdef RGMII_RX_FCS_CHECK_EN
            crc_q      <= 32'h0000_0000;
`endif
            tdata_q    <= 8'h00;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tuser_q    <= 1'b0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
            flen_q     <= 16'd0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
`ifdef RGMII_RX_FCS_CHECK_EN
            crc_q      <= crc_d;
`endif
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            tuser_q    <= tuser_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
            flen_q     <= flen_d;
        end
    end

    assign m_tdata_o    = tdata_q;
    assign m_tvalid_o   = tvalid_q;
    assign m_tlast_o    = tlast_q;
    assign m_tuser_o    = tuser_q;
    assign frame_done_o = done_q;
    assign frame_err_o  = ferr_q;
    assign frame_len_o  = flen_q;

endmodule

// File: tb/tb_rgmii_rx_framer.sv
// Scoreboard bench for rgmii_rx_framer: frames are generated with random
// content, the expected beats and frame status are derived from the framing
// rules and pushed into queues, and a monitor compares DUT output as it comes.
module tb_rgmii_rx_framer;

    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    typedef struct packed {
        logic        err;
        logic [15:0] len;
        logic        has_beat;
    } done_t;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic [3:0] rxd = 4'h0;
    logic       ctl = 1'b0;

    rgmii_rx_framer_if bus ();

    always #4 clk = ~clk;

    rgmii_rx_framer #(
        .MIN_FRAME_LEN (MIN_LEN),
        .MAX_FRAME_LEN (MAX_LEN)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .rgmii_rxd_i    (rxd),
        .rgmii_rx_ctl_i (ctl),
        .m_tdata_o      (bus.tdata),
        .m_tvalid_o     (bus.tvalid),
        .m_tlast_o      (bus.tlast),
        .m_tuser_o      (bus.tuser),
        .frame_done_o   (bus.frame_done),
        .frame_err_o    (bus.frame_err),
        .frame_len_o    (bus.frame_len)
    );

    beat_t      beat_q[$];
    done_t      done_q[$];
    beat_t      exp_b;
    done_t      exp_d;
    int         n_checks = 0;
    int         n_fail   = 0;
    bit         ignore_beats = 1'b0;
    logic [7:0] fb[$];
    bit         fe[$];

    // Monitor: every beat and every frame-done pulse is checked against the queues.
    always @(negedge clk) begin
        if (!rst_i) begin
            if (bus.tvalid) begin
                n_checks++;
                if (ignore_beats) begin
                    if (bus.tlast) begin
                        n_fail++;
                        $display("FAIL reset_abandon: tlast=1 on abandoned frame, required 0");
                    end
                end else if (beat_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat: data=%02h last=%0b, required no beat", bus.tdata, bus.tlast);
                end else begin
                    exp_b = beat_q.pop_front();
                    if (bus.tdata !== exp_b.data || bus.tlast !== exp_b.last ||
                        (exp_b.last && bus.tuser !== exp_b.user)) begin
                        n_fail++;
                        $display("FAIL beat: got data=%02h last=%0b user=%0b, required data=%02h last=%0b user=%0b",
                                 bus.tdata, bus.tlast, bus.tuser, exp_b.data, exp_b.last, exp_b.user);
                    end
                end
            end
            if (bus.frame_done) begin
                n_checks++;
                if (done_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_done: err=%0b len=%0d, required no frame_done", bus.frame_err, bus.frame_len);
                end else begin
                    exp_d = done_q.pop_front();
                    if (bus.frame_err !== exp_d.err || bus.frame_len !== exp_d.len ||
                        bus.tlast !== exp_d.has_beat) begin
                        n_fail++;
                        $display("FAIL frame_done: got err=%0b len=%0d tlast=%0b, required err=%0b len=%0d tlast=%0b",
                                 bus.frame_err, bus.frame_len, bus.tlast, exp_d.err, exp_d.len, exp_d.has_beat);
                    end
                end
            end
        end
    end

    // Standard reflected Ethernet CRC over the first n bytes of fb (final value, inverted).
    function automatic logic [31:0] ref_crc(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, fb[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    task automatic drive(input logic [7:0] b, input bit dv, input bit er);
        @(negedge clk);
        #1;
        rxd = b[3:0];
        ctl = dv;
        @(posedge clk);
        #1;
        rxd = b[7:4];
        ctl = dv ^ er;
    endtask

    task automatic idle(input int n, input bit false_carrier);
        for (int i = 0; i < n; i++) begin
            if (false_carrier && (i % 3 == 1)) begin
                drive(8'h0E, 1'b0, 1'b1);
            end else begin
                drive(8'h00, 1'b0, 1'b0);
            end
        end
    endtask

    task automatic build_frame(input int n_payload, input bit add_fcs);
        logic [31:0] c;
        fb.delete();
        fe.delete();
        for (int i = 0; i < n_payload; i++) begin
            fb.push_back(8'($urandom_range(0, 255)));
            fe.push_back(1'b0);
        end
        if (add_fcs) begin
            c = ref_crc(n_payload);
            for (int i = 0; i < 4; i++) begin
                fb.push_back(c[8*i +: 8]);
                fe.push_back(1'b0);
            end
        end
    endtask

    // Derive the expected output from the framing rules, then drive the frame.
    task automatic send_frame(input int pre_n, input logic [7:0] sfd, input bit fc);
        int    n, lim;
        bit    user, any_er, fcs_bad;
        beat_t b;
        done_t d;
        n = fb.size();
        if (sfd == 8'hD5) begin
            if (n == 0) begin
                d.err = 1'b1; d.len = 16'd0; d.has_beat = 1'b0;
                done_q.push_back(d);
            end else begin
                lim     = (n > MAX_LEN) ? MAX_LEN + 1 : n;
                any_er  = 1'b0;
                for (int i = 0; i < lim; i++) any_er |= fe[i];
                fcs_bad = 1'b0;
`ifdef RGMII_RX_FCS_CHECK_EN
                if (n < 4) begin
                    fcs_bad = 1'b1;
                end else begin
                    fcs_bad = (ref_crc(n - 4) != {fb[n-1], fb[n-2], fb[n-3], fb[n-4]});
                end
`endif
                user = (n > MAX_LEN) || any_er || (lim < MIN_LEN) || fcs_bad;
                for (int i = 0; i < lim; i++) begin
                    b.data = fb[i];
                    b.last = (i == lim - 1);
                    b.user = b.last ? user : 1'b0;
                    beat_q.push_back(b);
                end
                d.err = user; d.len = 16'(lim); d.has_beat = 1'b1;
                done_q.push_back(d);
            end
        end
        for (int i = 0; i < pre_n; i++) drive(8'h55, 1'b1, 1'b0);
        drive(sfd, 1'b1, 1'b0);
        for (int i = 0; i < n; i++) drive(fb[i], 1'b1, fe[i]);
        idle(12, fc);
    endtask

    task automatic check_zero(input string name);
        n_checks++;
        if (bus.tvalid !== 1'b0 || bus.tlast !== 1'b0 || bus.tuser !== 1'b0 ||
            bus.frame_done !== 1'b0 || bus.frame_err !== 1'b0 ||
            bus.tdata !== 8'h00 || bus.frame_len !== 16'd0) begin
            n_fail++;
            $display("FAIL %s: got valid=%0b last=%0b user=%0b done=%0b err=%0b data=%02h len=%0d, required all 0",
                     name, bus.tvalid, bus.tlast, bus.tuser, bus.frame_done, bus.frame_err, bus.tdata, bus.frame_len);
        end
    endtask

    initial begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_zero("reset_state");
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        idle(4, 1'b0);

        // Good 64-byte frame.
        build_frame(60, 1'b1);
        send_frame(7, 8'hD5, 1'b0);
        // Same size with er on byte 10.
        build_frame(60, 1'b1);
        fe[9] = 1'b1;
        send_frame(7, 8'hD5, 1'b1);
        // Runt.
        build_frame(20, 1'b0);
        send_frame(7, 8'hD5, 1'b0);
        // SFD then dv low.
        fb.delete();
        fe.delete();
        send_frame(7, 8'hD5, 1'b0);
        // FCS bit flipped.
        build_frame(60, 1'b1);
        fb[62] = fb[62] ^ 8'h10;
        send_frame(7, 8'hD5, 1'b0);
        // Oversize followed by a normal frame.
        build_frame(1600, 1'b0);
        send_frame(7, 8'hD5, 1'b0);
        build_frame(60, 1'b1);
        send_frame(7, 8'hD5, 1'b0);
        // Corrupted preamble: nothing expected.
        build_frame(64, 1'b0);
        send_frame(2, 8'h5A, 1'b0);

        // Reset in the middle of a frame; after release dv stays high on non-preamble bytes.
        ignore_beats = 1'b1;
        fork
            begin
                for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
                drive(8'hD5, 1'b1, 1'b0);
                for (int i = 0; i < 40; i++) drive(8'h3C, 1'b1, 1'b0);
                idle(12, 1'b0);
            end
            begin
                repeat (14) @(posedge clk);
                #2;
                rst_i = 1'b1;
                @(posedge clk);
                @(negedge clk);
                check_zero("reset_mid_frame");
                @(posedge clk);
                #2;
                rst_i = 1'b0;
                ignore_beats = 1'b0;
            end
        join

        // Randomized frames.
        for (int f = 0; f < 14; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                build_frame($urandom_range(1, 80), 1'b0);
            end else begin
                build_frame($urandom_range(0, 90), 1'b1);
            end
            if ($urandom_range(0, 3) == 0 && fb.size() > 0) begin
                fe[$urandom_range(0, fb.size() - 1)] = 1'b1;
            end
            send_frame($urandom_range(0, 7), 8'hD5, 1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 200 && (beat_q.size() != 0 || done_q.size() != 0); i++) begin
            @(posedge clk);
        end
        n_checks++;
        if (beat_q.size() != 0 || done_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d beats and %0d frame_done still pending, required 0 and 0",
                     beat_q.size(), done_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
